// File: rtl/axis_spi_pkg.sv
// Shared types and constants for the axis_spi block family.
// Contains the arbiter state encoding and the byte width used on every
// AXI-Stream path between requesters, arbiter and the SPI master.
package axis_spi_pkg;

    localparam int unsigned DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } arb_state_e;

endpackage

// File: rtl/axis_spi_rr_picker.sv
// Combinational requester picker.
// Returns the first asserted request at or after ptr_i (wrapping modulo
// REQ_NUM) as a one-hot vector plus its binary index. valid_o flags that
// at least one request was present.
module axis_spi_rr_picker #(
    parameter int unsigned REQ_NUM   = 4,
    parameter int unsigned REQ_WIDTH = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic [REQ_NUM-1:0]   req_i,
    input  logic [REQ_WIDTH-1:0] ptr_i,
    output logic [REQ_NUM-1:0]   grant_o,
    output logic [REQ_WIDTH-1:0] idx_o,
    output logic                 valid_o
);

    logic [REQ_WIDTH-1:0] cand;

    // Scan REQ_NUM positions starting at the pointer; the first hit wins.
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < REQ_NUM; i++) begin
            cand = REQ_WIDTH'((32'(ptr_i) + i) % REQ_NUM);
            if (!valid_o && req_i[cand]) begin
                valid_o       = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

endmodule

// File: rtl/axis_spi_arbiter.sv
// Packet arbiter sharing one axis_spi_master between REQ_NUM requesters.
// A grant covers a full request packet (up to request tlast) and is held
// until the master's response beat with tlast is accepted, so the target
// address stays stable through CS deassertion and the WAIT gap.
// Build option: define AXIS_SPI_ARB_FIXED_PRIO_EN for fixed priority
// (lowest index wins); the default build is round-robin.
module axis_spi_arbiter
    import axis_spi_pkg::*;
#(
    parameter int unsigned REQ_NUM    = 4,
    parameter int unsigned SLAVE_NUM  = 1,
    parameter int unsigned ADDR_WIDTH = (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1,
    parameter int unsigned REQ_WIDTH  = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
    input  logic                             clk_i,
    input  logic                             arstn_i,
    input  logic [REQ_NUM*DATA_WIDTH-1:0]    req_tdata_i,
    input  logic [REQ_NUM-1:0]               req_tvalid_i,
    input  logic [REQ_NUM-1:0]               req_tlast_i,
    input  logic [REQ_NUM*ADDR_WIDTH-1:0]    req_addr_i,
    output logic [REQ_NUM-1:0]               req_tready_o,
    output logic [DATA_WIDTH-1:0]            rsp_tdata_o,
    output logic [REQ_NUM-1:0]               rsp_tvalid_o,
    output logic                             rsp_tlast_o,
    input  logic [REQ_NUM-1:0]               rsp_tready_i,
    output logic [DATA_WIDTH-1:0]            spi_tdata_o,
    output logic                             spi_tvalid_o,
    output logic                             spi_tlast_o,
    input  logic                             spi_tready_i,
    output logic [ADDR_WIDTH-1:0]            spi_addr_o,
    input  logic [DATA_WIDTH-1:0]            spi_rsp_tdata_i,
    input  logic                             spi_rsp_tvalid_i,
    input  logic                             spi_rsp_tlast_i,
    output logic                             spi_rsp_tready_o,
    output logic [REQ_NUM-1:0]               grant_o,
    output logic                             busy_o
);

    arb_state_e state_q, state_d;

    logic [REQ_NUM-1:0]    grant_q;
    logic [REQ_WIDTH-1:0]  gidx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [REQ_WIDTH-1:0]  pick_ptr;
    logic [REQ_NUM-1:0]    pick_grant;
    logic [REQ_WIDTH-1:0]  pick_idx;
    logic                  pick_valid;
    logic                  release_now;

    logic [DATA_WIDTH-1:0] req_data [REQ_NUM];
    logic [ADDR_WIDTH-1:0] req_addr [REQ_NUM];

    // Split the flat request buses into per-requester lanes.
    always_comb begin
        for (int unsigned k = 0; k < REQ_NUM; k++) begin
            req_data[k] = req_tdata_i[k*DATA_WIDTH +: DATA_WIDTH];
            req_addr[k] = req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        end
    end

`ifdef AXIS_SPI_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [REQ_WIDTH-1:0] ptr_q;
    logic [REQ_WIDTH-1:0] next_ptr;

    assign pick_ptr = ptr_q;
    assign next_ptr = (gidx_q == REQ_WIDTH'(REQ_NUM - 1)) ? '0 : gidx_q + REQ_WIDTH'(1);

    // Round-robin pointer advances past the owner when its grant is released.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            ptr_q <= '0;
        end else if (release_now) begin
            ptr_q <= next_ptr;
        end
    end
`endif

    axis_spi_rr_picker #(
        .REQ_NUM   (REQ_NUM),
        .REQ_WIDTH (REQ_WIDTH)
    ) u_picker (
        .req_i   (req_tvalid_i),
        .ptr_i   (pick_ptr),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Next state plus TX/RX routing to the current owner.
    always_comb begin
        state_d          = state_q;
        release_now      = 1'b0;
        spi_tdata_o      = '0;
        spi_tvalid_o     = 1'b0;
        spi_tlast_o      = 1'b0;
        req_tready_o     = '0;
        rsp_tvalid_o     = '0;
        spi_rsp_tready_o = 1'b1;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                spi_tdata_o          = req_data[gidx_q];
                spi_tvalid_o         = req_tvalid_i[gidx_q];
                spi_tlast_o          = req_tlast_i[gidx_q];
                req_tready_o[gidx_q] = spi_tready_i;
                rsp_tvalid_o[gidx_q] = spi_rsp_tvalid_i;
                spi_rsp_tready_o     = rsp_tready_i[gidx_q];
                if (spi_tvalid_o && spi_tready_i && spi_tlast_o) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                rsp_tvalid_o[gidx_q] = spi_rsp_tvalid_i;
                spi_rsp_tready_o     = rsp_tready_i[gidx_q];
                if (spi_rsp_tvalid_i && spi_rsp_tready_o && spi_rsp_tlast_i) begin
                    state_d     = IDLE;
                    release_now = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; owner and target address are captured at grant time.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                grant_q <= pick_grant;
                gidx_q  <= pick_idx;
                addr_q  <= req_addr[pick_idx];
            end else if (release_now) begin
                grant_q <= '0;
            end
        end
    end

    assign rsp_tdata_o = spi_rsp_tdata_i;
    assign rsp_tlast_o = spi_rsp_tlast_i;
    assign spi_addr_o  = addr_q;
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_axis_spi_arbiter.sv
// Self-checking bench for axis_spi_arbiter: requester queues and an SPI
// master model drive the DUT; a packet-level ownership model predicts
// every output each cycle. Honours AXIS_SPI_ARB_FIXED_PRIO_EN.
module tb_axis_spi_arbiter;

    localparam int N  = 4;
    localparam int SN = 2;
    localparam int AW = 1;
    localparam int DW = 8;

    logic            clk_i = 1'b0;
    logic            arstn_i;
    logic [N*DW-1:0] req_tdata_i;
    logic [N-1:0]    req_tvalid_i;
    logic [N-1:0]    req_tlast_i;
    logic [N*AW-1:0] req_addr_i;
    logic [N-1:0]    req_tready_o;
    logic [DW-1:0]   rsp_tdata_o;
    logic [N-1:0]    rsp_tvalid_o;
    logic            rsp_tlast_o;
    logic [N-1:0]    rsp_tready_i;
    logic [DW-1:0]   spi_tdata_o;
    logic            spi_tvalid_o;
    logic            spi_tlast_o;
    logic            spi_tready_i;
    logic [AW-1:0]   spi_addr_o;
    logic [DW-1:0]   spi_rsp_tdata_i;
    logic            spi_rsp_tvalid_i;
    logic            spi_rsp_tlast_i;
    logic            spi_rsp_tready_o;
    logic [N-1:0]    grant_o;
    logic            busy_o;

    axis_spi_arbiter #(
        .REQ_NUM   (N),
        .SLAVE_NUM (SN)
    ) dut (
        .clk_i            (clk_i),
        .arstn_i          (arstn_i),
        .req_tdata_i      (req_tdata_i),
        .req_tvalid_i     (req_tvalid_i),
        .req_tlast_i      (req_tlast_i),
        .req_addr_i       (req_addr_i),
        .req_tready_o     (req_tready_o),
        .rsp_tdata_o      (rsp_tdata_o),
        .rsp_tvalid_o     (rsp_tvalid_o),
        .rsp_tlast_o      (rsp_tlast_o),
        .rsp_tready_i     (rsp_tready_i),
        .spi_tdata_o      (spi_tdata_o),
        .spi_tvalid_o     (spi_tvalid_o),
        .spi_tlast_o      (spi_tlast_o),
        .spi_tready_i     (spi_tready_i),
        .spi_addr_o       (spi_addr_o),
        .spi_rsp_tdata_i  (spi_rsp_tdata_i),
        .spi_rsp_tvalid_i (spi_rsp_tvalid_i),
        .spi_rsp_tlast_i  (spi_rsp_tlast_i),
        .spi_rsp_tready_o (spi_rsp_tready_o),
        .grant_o          (grant_o),
        .busy_o           (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Model state: owner is -1 when no packet holds the master.
    int          owner;
    bit          sent_last;
    int          ptr;
    logic [AW-1:0] exp_addr;

    logic [7:0]  qd [N][$];
    bit          ql [N][$];
    logic [AW-1:0] addr_reg [N];
    bit          gate [N];
    bit          rsp_rdy [N];
    bit          tready;
    bit          rnd_mode;

    logic [7:0]  pend_d [$];
    bit          pend_l [$];
    logic [7:0]  md [$];
    bit          ml [$];
    int          wait_cnt;

    int          grant_log [$];
    int          rx_cnt [N];
    int          rx_last [N];

    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int k);
        logic [N-1:0] r;
        r = '0;
        if (k >= 0) r[k] = 1'b1;
        return r;
    endfunction

    function automatic bit done();
        bit r;
        r = (owner < 0) && (md.size() == 0) && (pend_d.size() == 0) && (wait_cnt == 0);
        for (int k = 0; k < N; k++) if (qd[k].size() != 0) r = 0;
        return r;
    endfunction

    task automatic add_pkt(input int k, input int len, input logic [31:0] bytes);
        logic [31:0] b;
        b = bytes;
        for (int i = 0; i < len; i++) begin
            qd[k].push_back(b[8*i +: 8]);
            ql[k].push_back(i == len - 1);
        end
    endtask

    task automatic drive();
        if (rnd_mode) begin
            tready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) rsp_rdy[k] = ($urandom_range(0, 3) != 0);
        end
        for (int k = 0; k < N; k++) begin
            req_tvalid_i[k]         = gate[k] && (qd[k].size() > 0);
            req_tdata_i[k*DW +: DW] = (qd[k].size() > 0) ? qd[k][0] : 8'h00;
            req_tlast_i[k]          = (ql[k].size() > 0) ? ql[k][0] : 1'b0;
            req_addr_i[k*AW +: AW]  = addr_reg[k];
            rsp_tready_i[k]         = rsp_rdy[k];
        end
        spi_tready_i     = tready;
        spi_rsp_tvalid_i = (md.size() > 0);
        spi_rsp_tdata_i  = (md.size() > 0) ? md[0] : 8'h00;
        spi_rsp_tlast_i  = (ml.size() > 0) ? ml[0] : 1'b0;
    endtask

    task automatic evaluate();
        logic [N-1:0] eg, vld;
        bit etv, mv, esr, txf, rxf, l;
        logic [7:0] d;
        int o, start, k;
        o   = owner;
        eg  = onehot(o);
        vld = req_tvalid_i;
        check("grant", grant_o, eg);
        check("busy", busy_o, o >= 0);
        check("addr", spi_addr_o, exp_addr);
        etv = (o >= 0) && !sent_last && vld[o];
        check("tx_valid", spi_tvalid_o, etv);
        if (etv) begin
            check("tx_data", spi_tdata_o, qd[o][0]);
            check("tx_last", spi_tlast_o, ql[o][0]);
        end
        check("req_tready", req_tready_o, ((o >= 0) && !sent_last && tready) ? eg : '0);
        mv = (md.size() > 0);
        check("rsp_valid", rsp_tvalid_o, ((o >= 0) && mv) ? eg : '0);
        esr = (o >= 0) ? rsp_rdy[o] : 1'b1;
        check("spi_rsp_tready", spi_rsp_tready_o, esr);
        if (mv) begin
            check("rsp_data", rsp_tdata_o, md[0]);
            check("rsp_last", rsp_tlast_o, ml[0]);
        end
        txf = etv && tready;
        rxf = mv && esr;
        // Master: responses appear after CS deassert plus a WAIT gap.
        if (wait_cnt > 0) begin
            wait_cnt--;
            if (wait_cnt == 0) begin
                while (pend_d.size() > 0) begin
                    md.push_back(pend_d.pop_front());
                    ml.push_back(pend_l.pop_front());
                end
            end
        end
        if (txf) begin
            d = qd[o].pop_front();
            l = ql[o].pop_front();
            pend_d.push_back(d ^ 8'hC3);
            pend_l.push_back(l);
            if (l) begin
                sent_last = 1'b1;
                wait_cnt  = 3;
            end
        end
        if (rxf) begin
            d = md.pop_front();
            l = ml.pop_front();
            if (o >= 0) begin
                rx_cnt[o]++;
                if (l) rx_last[o]++;
                if (sent_last && l) begin
                    ptr       = (o + 1) % N;
                    owner     = -1;
                    sent_last = 1'b0;
                end
            end
        end
        if (o < 0 && vld != '0) begin
`ifdef AXIS_SPI_ARB_FIXED_PRIO_EN
            start = 0;
`else
            start = ptr;
`endif
            for (int i = 0; i < N; i++) begin
                k = (start + i) % N;
                if (vld[k]) begin
                    owner     = k;
                    sent_last = 1'b0;
                    exp_addr  = addr_reg[k];
                    grant_log.push_back(k);
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        #1;
        drive();
        @(negedge clk_i);
        evaluate();
    endtask

    task automatic run(input string tag, input int budget);
        int c;
        c = 0;
        do begin
            cycle();
            c++;
        end while (!done() && c < budget);
        check({tag, "_drain"}, done(), 1);
    endtask

    task automatic clear_counts();
        grant_log.delete();
        for (int k = 0; k < N; k++) begin
            rx_cnt[k]  = 0;
            rx_last[k] = 0;
        end
    endtask

    task automatic model_reset();
        owner     = -1;
        sent_last = 1'b0;
        ptr       = 0;
        exp_addr  = '0;
        wait_cnt  = 0;
        pend_d.delete();
        pend_l.delete();
        md.delete();
        ml.delete();
        for (int k = 0; k < N; k++) begin
            qd[k].delete();
            ql[k].delete();
        end
    endtask

    initial begin
        int c;
        int exp_order [4];

        arstn_i  = 1'b0;
        tready   = 1'b1;
        rnd_mode = 1'b0;
        for (int k = 0; k < N; k++) begin
            gate[k]     = 1'b1;
            rsp_rdy[k]  = 1'b1;
            addr_reg[k] = '0;
        end
        model_reset();
        clear_counts();
        drive();
        #2;
        check("rst_grant", grant_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_addr", spi_addr_o, 0);
        check("rst_tx_valid", spi_tvalid_o, 0);
        check("rst_req_tready", req_tready_o, 0);
        check("rst_rsp_valid", rsp_tvalid_o, 0);
        check("rst_spi_rsp_tready", spi_rsp_tready_o, 1);
        @(negedge clk_i);
        @(negedge clk_i);
        arstn_i = 1'b1;

        // Stray response while idle is accepted and discarded.
        md.push_back(8'h77);
        ml.push_back(1'b1);
        run("stray", 10);

        // Single requester 2, three bytes, slave 1.
        clear_counts();
        addr_reg[2] = 1'b1;
        add_pkt(2, 3, 32'h00FF5AA5);
        run("t1", 200);
        check("t1_grants", grant_log.size(), 1);
        if (grant_log.size() > 0) check("t1_owner", grant_log[0], 2);
        check("t1_rx_cnt", rx_cnt[2], 3);
        check("t1_rx_last", rx_last[2], 1);
        check("t1_rx_other", rx_cnt[0] + rx_cnt[1] + rx_cnt[3], 0);

        // Move the pointer to 0, then requesters 0 and 3 contend.
        add_pkt(3, 1, 32'h11);
        run("t2pre", 100);
        clear_counts();
        add_pkt(0, 1, 32'h21);
        add_pkt(0, 1, 32'h22);
        add_pkt(3, 1, 32'h31);
        add_pkt(3, 1, 32'h32);
`ifdef AXIS_SPI_ARB_FIXED_PRIO_EN
        exp_order = '{0, 0, 3, 3};
`else
        exp_order = '{0, 3, 0, 3};
`endif
        run("t2", 300);
        check("t2_grants", grant_log.size(), 4);
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check($sformatf("t2_order%0d", i), grant_log[i], exp_order[i]);

        // Owner stalls for 20 cycles while requester 1 waits.
        clear_counts();
        add_pkt(0, 3, 32'h00030201);
        add_pkt(1, 1, 32'h44);
        c = 0;
        while (qd[0].size() != 2 && c < 50) begin
            cycle();
            c++;
        end
        check("t3_first_beat", qd[0].size(), 2);
        gate[0] = 1'b0;
        repeat (20) cycle();
        check("t3_grant_held", grant_o, 4'b0001);
        check("t3_tx_idle", spi_tvalid_o, 0);
        gate[0] = 1'b1;
        run("t3", 200);
        check("t3_grants", grant_log.size(), 2);
        if (grant_log.size() > 1) check("t3_second", grant_log[1], 1);

        // Address change after grant is ignored.
        addr_reg[1] = 1'b0;
        add_pkt(1, 3, 32'h00ABCDEF);
        tready = 1'b0;
        c = 0;
        while (owner != 1 && c < 50) begin
            cycle();
            c++;
        end
        check("t4_owner", owner, 1);
        addr_reg[1] = 1'b1;
        repeat (3) cycle();
        tready = 1'b1;
        run("t4", 200);
        check("t4_addr_kept", spi_addr_o, 0);

        // Owner holds off the response for 10 cycles.
        add_pkt(1, 2, 32'h00005566);
        c = 0;
        while (md.size() == 0 && c < 50) begin
            cycle();
            c++;
        end
        check("t5_rsp_ready", md.size() > 0, 1);
        rsp_rdy[1] = 1'b0;
        repeat (10) cycle();
        check("t5_busy_held", busy_o, 1);
        check("t5_grant_held", grant_o, 4'b0010);
        rsp_rdy[1] = 1'b1;
        run("t5", 100);

        // Randomised traffic from all requesters.
        rnd_mode = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int k = 0; k < N; k++) begin
                if (qd[k].size() == 0 && $urandom_range(0, 7) == 0) begin
                    addr_reg[k] = AW'($urandom_range(0, 1));
                    add_pkt(k, $urandom_range(1, 4), $urandom);
                end
            end
            cycle();
        end
        run("rnd", 3000);
        rnd_mode = 1'b0;
        tready   = 1'b1;
        for (int k = 0; k < N; k++) rsp_rdy[k] = 1'b1;

        // Reset mid-packet with the pointer away from 0.
        add_pkt(2, 1, 32'h99);
        run("t6pre", 100);
        addr_reg[3] = 1'b1;
        add_pkt(3, 3, 32'h00123456);
        tready = 1'b0;
        c = 0;
        while (owner != 3 && c < 50) begin
            cycle();
            c++;
        end
        repeat (2) cycle();
        check("t6_owner", grant_o, 4'b1000);
        @(posedge clk_i);
        #2;
        arstn_i = 1'b0;
        #1;
        check("t6_rst_grant", grant_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_addr", spi_addr_o, 0);
        model_reset();
        tready = 1'b1;
        drive();
        @(negedge clk_i);
        @(negedge clk_i);
        arstn_i = 1'b1;
        clear_counts();
        add_pkt(0, 1, 32'h01);
        add_pkt(3, 1, 32'h03);
        run("t6", 200);
        check("t6_grants", grant_log.size(), 2);
        if (grant_log.size() > 0) check("t6_first", grant_log[0], 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/axis_spi_arbiter.md
Name: axis_spi_arbiter

Overview:
- Shares one axis_spi_master between REQ_NUM independent AXI-Stream requesters, each of which names its own target slave.
- Grants the SPI master for a whole packet, which ends at the request tlast. The grant is held until the master returns the response beat carrying tlast, i.e. after CS deassertion and the WAIT gap.
- Drives the master's addr_i, forwards request beats to it and routes received bytes back to the owning requester.
- Sits between the requester fabric (CPU bridge, flash loader, sensor poller) and axis_spi_master.

Parameters:
- REQ_NUM, 4, number of requesters (2..16).
- SLAVE_NUM, 1, number of SPI chip selects on the shared master.
- ADDR_WIDTH, (SLAVE_NUM>1 ? $clog2(SLAVE_NUM) : 1), width of a slave address.
- REQ_WIDTH, (REQ_NUM>1 ? $clog2(REQ_NUM) : 1), width of a requester index.

Ports:
- clk_i  in  1  clock (one clock; reset is asynchronous and active-low)
- arstn_i  in  1  asynchronous active-low reset
- req_tdata_i  in  REQ_NUM*DATA_WIDTH  request bytes; requester k occupies slice k
- req_tvalid_i  in  REQ_NUM  per-requester tvalid
- req_tlast_i  in  REQ_NUM  per-requester tlast (end of SPI frame)
- req_addr_i  in  REQ_NUM*ADDR_WIDTH  target slave per requester; sampled at grant
- req_tready_o  out  REQ_NUM  per-requester tready
- rsp_tdata_o  out  DATA_WIDTH  received byte, shared by all requesters
- rsp_tvalid_o  out  REQ_NUM  per-requester tvalid (owner only)
- rsp_tlast_o  out  1  response tlast
- rsp_tready_i  in  REQ_NUM  per-requester tready
- spi_tdata_o / spi_tvalid_o / spi_tlast_o  out  DATA_WIDTH/1/1  to master s_axis
- spi_tready_i  in  1  from master s_axis
- spi_addr_o  out  ADDR_WIDTH  to master addr_i
- spi_rsp_tdata_i / spi_rsp_tvalid_i / spi_rsp_tlast_i  in  DATA_WIDTH/1/1  from master m_axis
- spi_rsp_tready_o  out  1  to master m_axis
- grant_o  out  REQ_NUM  one-hot current owner, 0 when idle
- busy_o  out  1  a grant is held

Behaviour:
- Reset values: grant_o=0, busy_o=0, spi_addr_o=0, RR pointer=0, state=IDLE. All tvalid/tready outputs are 0 except spi_rsp_tready_o=1.
- State machine has three states: IDLE, XFER, RESP.
- IDLE: if any req_tvalid_i is set at cycle t, the picker selects the first requester at or after the pointer (wrapping). At t+1: grant_o and busy_o are set, spi_addr_o is latched from that requester's req_addr_i, and the state moves to XFER. There is no beat transfer in cycle t.
- XFER: the TX path is combinational pass-through for the owner g.
  - spi_tdata_o = req_tdata_i[g]; spi_tvalid_o = req_tvalid_i[g]; spi_tlast_o = req_tlast_i[g].
  - req_tready_o[g] = spi_tready_i; all other req_tready_o bits are 0.
  - A handshake with tlast=1 moves the state to RESP and blocks further TX beats.
- XFER and RESP: the RX path routes to g.
  - rsp_tvalid_o[g] = spi_rsp_tvalid_i; spi_rsp_tready_o = rsp_tready_i[g].
  - rsp_tdata_o and rsp_tlast_o are driven directly from the master.
- RESP: on the response handshake with spi_rsp_tlast_i=1, grant_o is cleared, the pointer becomes g+1 (mod REQ_NUM) and the state returns to IDLE on the next edge.
- Simultaneous events: the release cycle never grants. Re-arbitration starts the cycle after IDLE is entered, giving a minimum gap of 1 idle cycle between packets.
- The owner dropping tvalid mid-packet does not release the grant; the arbiter waits indefinitely.
- A change of req_addr_i after grant is ignored; spi_addr_o is stable for the whole packet including the WAIT gap.
- In IDLE, response beats have no owner: spi_rsp_tready_o=1 and the beats are discarded.
- Asynchronous reset mid-packet returns to reset values immediately. The master shares the same reset.
- REQ_NUM=1 degenerates to pass-through with the same grant/release sequencing.

Optional Feature:
- Macro: AXIS_SPI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins. The pointer is not used and is held at 0.
- Undefined (default): round-robin as described above.

Decomposition:
- axis_spi_pkg gains the typedef arb_state_e {IDLE, XFER, RESP}. DATA_WIDTH is reused from that package.
- Sub-module axis_spi_rr_picker: combinational picker taking a request vector and pointer, outputting a one-hot grant and its index. Under AXIS_SPI_ARB_FIXED_PRIO_EN the pointer input is tied to 0.

Test Plan:
- Single requester 2 sends 3 bytes 0xA5,0x5A,0xFF (tlast on the third), addr=1 → spi_addr_o=1 from the grant cycle through the response tlast. grant_o=4'b0100. Requester 2 receives 3 bytes with tlast on the third; rsp_tvalid_o for requesters 0, 1 and 3 never asserts.
- Requesters 0 and 3 both hold 1-byte packets continuously → grants alternate 0,3,0,3, each separated by exactly one idle cycle. With AXIS_SPI_ARB_FIXED_PRIO_EN defined, only requester 0 is served.
- The owner drops tvalid for 20 cycles mid-packet while requester 1 is requesting → grant_o is unchanged and spi_tvalid_o=0 during the gap. The packet then completes normally.
- Requester 1's req_addr_i changes from 0 to 1 after grant → spi_addr_o stays 0 until release.
- rsp_tready_i of the owner held low for 10 cycles → spi_rsp_tready_o=0 for those cycles and the master's m_axis tdata is preserved. The grant is not released until the tlast beat is accepted.
- arstn_i asserted during XFER → grant_o=0, busy_o=0, spi_addr_o=0 asynchronously. After release, the first request is granted to index 0.
